// File: rtl/mod60_pkg.sv
// mod60_pkg: shared FSM state encoding, BCD limits and load-value check for mod60_timer_ctrl
package mod60_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, LOAD = 2'd3} state_t;
  localparam logic [3:0] BCD_MAX_ONES = 4'd9;
  function automatic logic bcd_valid(input logic [3:0] tens, input logic [3:0] ones, input logic [3:0] tmax);
    return (ones <= BCD_MAX_ONES) && (tens <= tmax);
  endfunction
endpackage

// File: rtl/mod60_timer_ctrl_bcd_digit.sv
// bcd_digit: one BCD digit counter with async clear, sync load and wrap at max
// Ports: clk, CR (async clear), en (count), ld/d (load value), max (wrap digit),
//        dir (1=down, only with COUNT_DOWN_EN), q (digit), tc (digit at terminal value)
module bcd_digit (
  input  logic       clk,
  input  logic       CR,
  input  logic       en,
  input  logic       ld,
  input  logic [3:0] d,
  input  logic [3:0] max,
`ifdef COUNT_DOWN_EN
  input  logic       dir,
`endif
  output logic [3:0] q,
  output logic       tc
);
  logic dn;
`ifdef COUNT_DOWN_EN
  assign dn = dir;
`else
  assign dn = 1'b0;
`endif
  always_ff @(posedge clk or posedge CR)
    if (CR) q <= '0;
    else if (ld) q <= d;
    else if (en) q <= dn ? ((q == 4'd0) ? max : q - 4'd1) : ((q == max) ? 4'd0 : q + 4'd1);
  assign tc = dn ? (q == 4'd0) : (q == max);
endmodule

// File: rtl/mod60_timer_ctrl.sv
// mod60_timer_ctrl: BCD modulo-(TENS_MAX+1)*10 timer with run/pause/load FSM
// Ports: clk, CR (async clear), tick (time base), start/stop/clr (commands),
//        ld_req/ld_val/ld_ack/ld_err (load handshake), tens/ones (count),
//        rco (carry), state (FSM state); dir (1=down) only with COUNT_DOWN_EN
// Macro COUNT_DOWN_EN enables the down-count direction input.
module mod60_timer_ctrl
  import mod60_pkg::*;
#(
  parameter int TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       CR,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clr,
  input  logic       ld_req,
  input  logic [7:0] ld_val,
`ifdef COUNT_DOWN_EN
  input  logic       dir,
`endif
  output logic       ld_ack,
  output logic       ld_err,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       rco,
  output logic [1:0] state
);
  localparam logic [3:0] TMAX = 4'(TENS_MAX);
  state_t st;
  logic valid, run_next, cnt_en, dig_ld, ones_tc, tens_tc;
  logic [3:0] d_ones, d_tens;
  assign valid    = bcd_valid(ld_val[7:4], ld_val[3:0], TMAX);
  assign run_next = (st == RUN) | (((st == IDLE) | (st == PAUSE)) & start);
  // a same-cycle tick only counts when no higher-priority command overrides the move to RUN
  assign cnt_en   = tick & run_next & ~clr & ~ld_req & ~stop;
  // sync clear reuses the digit load path with a zero value
  assign dig_ld   = clr | ((st == LOAD) & valid);
  assign d_ones   = clr ? 4'd0 : ld_val[3:0];
  assign d_tens   = clr ? 4'd0 : ld_val[7:4];
  assign rco      = ~CR & (st == RUN) & tick & ones_tc & tens_tc;
  assign state    = st;
  bcd_digit u_ones (
    .clk(clk), .CR(CR), .en(cnt_en), .ld(dig_ld), .d(d_ones), .max(BCD_MAX_ONES),
`ifdef COUNT_DOWN_EN
    .dir(dir),
`endif
    .q(ones), .tc(ones_tc)
  );
  bcd_digit u_tens (
    .clk(clk), .CR(CR), .en(cnt_en & ones_tc), .ld(dig_ld), .d(d_tens), .max(TMAX),
`ifdef COUNT_DOWN_EN
    .dir(dir),
`endif
    .q(tens), .tc(tens_tc)
  );
  // ld_ack is high for exactly the LOAD cycle; ld_err updates as LOAD completes
  always_ff @(posedge clk or posedge CR)
    if (CR) begin
      st     <= IDLE;
      ld_ack <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      ld_ack <= 1'b0;
      if (clr) begin
        st     <= IDLE;
        ld_err <= 1'b0;
      end else if (st == LOAD) begin
        st     <= IDLE;
        ld_err <= ~valid;
      end else if (ld_req) begin
        st     <= LOAD;
        ld_ack <= 1'b1;
      end else if (stop) st <= (st == RUN) ? PAUSE : st;
      else if (start) st <= RUN;
    end
endmodule

// File: tb/tb_mod60_timer_ctrl.sv
// tb_mod60_timer_ctrl: directed and random checks of mod60_timer_ctrl against a value-level model
module tb_mod60_timer_ctrl;
  localparam int TM = 5;
  localparam int M = (TM + 1) * 10;
  logic clk = 1'b0;
  logic CR, tick, start, stop, clr, ld_req;
  logic [7:0] ld_val;
  logic ld_ack, ld_err, rco;
  logic [3:0] tens, ones;
  logic [1:0] state;
  int vectors = 0, miscompares = 0;
  int m_v, m_st;
  logic m_err;
  always #5 clk = ~clk;
  mod60_timer_ctrl #(.TENS_MAX(TM)) dut (
    .clk(clk), .CR(CR), .tick(tick), .start(start), .stop(stop), .clr(clr),
    .ld_req(ld_req), .ld_val(ld_val), .ld_ack(ld_ack), .ld_err(ld_err),
    .tens(tens), .ones(ones), .rco(rco), .state(state)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all();
    chk("state", 8'(state), 8'(m_st));
    chk("tens", 8'(tens), 8'(m_v / 10));
    chk("ones", 8'(ones), 8'(m_v % 10));
    chk("ld_err", 8'(ld_err), 8'(m_err));
    chk("ld_ack", 8'(ld_ack), 8'(m_st == 3));
  endtask
  task automatic apply(input logic s, input logic p, input logic c, input logic l,
                       input logic [7:0] lv, input logic t);
    int nxt;
    start = s; stop = p; clr = c; ld_req = l; ld_val = lv; tick = t;
    #1;
    chk("rco", 8'(rco), 8'(m_st == 1 && t && m_v == M - 1));
    nxt = c ? 0 : (m_st == 3) ? 0 : l ? 3 : p ? ((m_st == 1) ? 2 : m_st) : s ? 1 : m_st;
    if (c) begin
      m_v = 0;
      m_err = 1'b0;
    end else if (m_st == 3) begin
      if (lv[3:0] <= 9 && int'(lv[7:4]) <= TM) begin
        m_v = int'(lv[7:4]) * 10 + int'(lv[3:0]);
        m_err = 1'b0;
      end else m_err = 1'b1;
    end else if (nxt == 1 && t) m_v = (m_v + 1) % M;
    m_st = nxt;
    @(negedge clk);
    chk_all();
  endtask
  initial begin
    CR = 1'b1; tick = 0; start = 0; stop = 0; clr = 0; ld_req = 0; ld_val = 0;
    m_v = 0; m_st = 0; m_err = 1'b0;
    repeat (2) @(negedge clk);
    chk_all();
    chk("rco_reset", 8'(rco), 8'd0);
    CR = 1'b0;
    apply(1, 0, 0, 0, 8'h00, 0);
    repeat (60) apply(0, 0, 0, 0, 8'h00, 1);
    chk("wrap00", {tens, ones}, 8'h00);
    repeat (5) apply(0, 0, 0, 0, 8'h00, 1);
    apply(0, 0, 0, 1, 8'h47, 0);
    apply(0, 0, 0, 1, 8'h47, 0);
    chk("load47", {tens, ones}, 8'h47);
    apply(1, 0, 0, 0, 8'h00, 0);
    repeat (13) apply(0, 0, 0, 0, 8'h00, 1);
    chk("resume00", {tens, ones}, 8'h00);
    repeat (7) apply(0, 0, 0, 0, 8'h00, 1);
    apply(0, 0, 0, 1, 8'h6A, 0);
    apply(0, 0, 0, 1, 8'h6A, 0);
    chk("bad_err", 8'(ld_err), 8'd1);
    chk("bad_keep", {tens, ones}, 8'h07);
    apply(0, 0, 1, 0, 8'h00, 0);
    chk("clr_err", 8'(ld_err), 8'd0);
    apply(1, 0, 0, 0, 8'h00, 0);
    repeat (12) apply(0, 0, 0, 0, 8'h00, 1);
    apply(0, 0, 1, 1, 8'h25, 1);
    chk("clr_prio", {tens, ones}, 8'h00);
    apply(1, 0, 0, 0, 8'h00, 0);
    repeat (30) apply(0, 0, 0, 0, 8'h00, 1);
    apply(0, 1, 0, 0, 8'h00, 1);
    chk("stop_hold", {tens, ones}, 8'h30);
    apply(1, 0, 0, 0, 8'h00, 0);
    repeat (3) apply(0, 0, 0, 0, 8'h00, 1);
    tick = 1'b1;
    #2 CR = 1'b1;
    #1;
    chk("async_cnt", {tens, ones}, 8'h00);
    chk("async_st", 8'(state), 8'd0);
    chk("async_rco", 8'(rco), 8'd0);
    chk("async_ack", 8'({ld_ack, ld_err}), 8'd0);
    @(negedge clk);
    CR = 1'b0;
    m_v = 0; m_st = 0; m_err = 1'b0;
    apply(1, 0, 0, 0, 8'h00, 0);
    apply(0, 0, 0, 0, 8'h00, 1);
    chk("after_cr", {tens, ones}, 8'h01);
    for (int i = 0; i < 600; i++) begin
      logic [7:0] lv;
      lv = ($urandom_range(0, 3) == 0) ? 8'($urandom) :
           {4'($urandom_range(0, TM)), 4'($urandom_range(0, 9))};
      apply($urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 19) == 0, lv, $urandom_range(0, 3) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mod60_timer_ctrl.md
MOD60_TIMER_CTRL -- requirements
Module: mod60_timer_ctrl

Interface
REQ-001 SHALL have parameter TENS_MAX, default 5, meaning the highest tens digit (5 gives modulo 60; legal range 1..9).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; every flop is rising-edge.
REQ-003 SHALL have port CR, input, 1 bit, asynchronous active-high reset (clear).
REQ-004 SHALL have port tick, input, 1 bit, single-cycle time-base pulse; counts only while RUN.
REQ-005 SHALL have ports start, stop and clr, each input, 1 bit, synchronous commands sampled every cycle.
REQ-006 SHALL have port ld_req, input, 1 bit, load request, held high until ld_ack.
REQ-007 SHALL have port ld_val, input, 8 bits, BCD load value {tens[7:4], ones[3:0]}.
REQ-008 SHALL have port ld_ack, output, 1 bit, one-cycle load acknowledge.
REQ-009 SHALL have port ld_err, output, 1 bit, sticky flag meaning the last load was rejected.
REQ-010 SHALL have ports tens and ones, output, 4 bits each, current BCD count.
REQ-011 SHALL have port rco, output, 1 bit, combinational carry: high when state==RUN & tick & count==terminal value.
REQ-012 SHALL have port state, output, 2 bits, encoded FSM state.

Function
REQ-013 SHALL implement FSM states IDLE=0, RUN=1, PAUSE=2, LOAD=3.
REQ-014 Command priority SHALL be clr > ld_req > stop > start.
- Commands are evaluated once per cycle.
- A tick in the same cycle counts only if the resulting state is RUN and no higher-priority command is active.
REQ-015 clr SHALL have this effect in any state:
- next cycle count=00 and state=IDLE;
- ld_err cleared;
- any pending load abandoned with no ld_ack.
REQ-016 Transitions SHALL be:
- IDLE/PAUSE + start -> RUN;
- RUN + stop -> PAUSE;
- IDLE/RUN/PAUSE + ld_req -> LOAD;
- LOAD -> IDLE after exactly 1 cycle.
REQ-017 In LOAD SHALL validate ld_val (ones<=9 and tens<=TENS_MAX), then:
- if valid: load it and clear ld_err;
- if invalid: keep count and set ld_err;
- in both cases assert ld_ack for that single cycle.
REQ-018 The requester SHALL drop ld_req after ld_ack; ld_req still high in the cycle after ld_ack SHALL start a new load.
REQ-019 In RUN with tick, ones SHALL increment; ones 9 -> 0 SHALL increment tens.
REQ-020 Count {TENS_MAX,9} + tick SHALL wrap to 00 with rco high in that cycle; counting SHALL continue in RUN.
REQ-021 IDLE, PAUSE and LOAD SHALL ignore tick and hold the count.
REQ-022 Count latency SHALL be 1 cycle: a tick at edge N updates tens/ones after edge N.

Reset
REQ-023 CR high SHALL immediately and asynchronously force:
- state=IDLE;
- tens=0, ones=0;
- ld_ack=0, ld_err=0.
REQ-024 While CR is high, rco SHALL read 0.
REQ-025 Deassertion of CR in the middle of a load SHALL return to IDLE with no ld_ack; commands SHALL be honoured from the first edge after release.

Configuration
REQ-026 Macro COUNT_DOWN_EN SHALL control the down-count feature.
- Defined: add input dir (1 bit; 1=down). Down-count 00 -> {TENS_MAX,9}, with terminal value 00 for rco.
- Undefined: no dir port, up-count only, terminal value {TENS_MAX,9}.

Structure
REQ-027 Package mod60_pkg SHALL hold:
- the state encoding constants;
- BCD_MAX_ONES=9;
- the helper function bcd_valid(tens, ones, tmax).
REQ-028 Sub-module bcd_digit SHALL be used twice (ones and tens).
- Ports: clk, CR, en, ld, d, max, q, tc.
- Priority: clear > load > enable.
- The tens instance gets en = ones.tc & count-enable.

Verification
REQ-029 Up-count: reset, start, 60 ticks -> count 00 again; rco high exactly on the tick at 59.
REQ-030 Load and resume: load 0x47 in RUN -> ld_ack 1 cycle, state IDLE, count 47, ld_err 0; then start, 13 ticks -> 00 with rco.
REQ-031 Invalid load: ld_val 0x6A -> ld_ack, ld_err 1, count unchanged; then clr -> ld_err 0.
REQ-032 Simultaneous commands: clr+ld_req+tick in RUN at count 12 -> count 00, IDLE, no ld_ack; stop+tick at count 30 -> PAUSE, count 30.
REQ-033 Reset mid-operation: assert CR between clock edges in RUN at count 33 -> outputs zero before the next edge; release, start, tick -> count 01.
REQ-034 With COUNT_DOWN_EN: dir=1 from 00, 1 tick -> count 59 with rco; TENS_MAX=2 and dir=0 -> wrap 29 -> 00.
